// File: rtl/vga_axil_regs.sv
// vga_axil_regs: AXI-Lite slave register file for the VGA pipeline.
// Decodes addr[4:2] into 32-bit word registers (CTRL, BG_COLOR, SCRATCH, FRAME_CNT).
// It runs the AW/W/B and AR/R handshakes as two independent FSMs.
// It exports the static pixel-stage controls and counts frame_start pulses.
// Optional feature: define VGA_AXIL_REGS_IRQ_EN to add STATUS (0x10, W1C frame_pend),
// IRQ_EN (0x14) and the registered irq output.
module vga_axil_regs #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic                  frame_start,
    output logic                  vga_en,
    output logic                  vga_test_pattern,
    output logic [11:0]           vga_bg_rgb
`ifdef VGA_AXIL_REGS_IRQ_EN
    ,
    output logic                  irq
`endif
);

    if (DATA_W != 32) begin : g_bad_data_w
        $fatal(1, "vga_axil_regs: DATA_W must be 32");
    end
    if (ADDR_W < 5) begin : g_bad_addr_w
        $fatal(1, "vga_axil_regs: ADDR_W must be at least 5 to decode addr[4:2]");
    end

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word index (addr[4:2]) of each register.
    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_BG_COLOR  = 3'd1;
    localparam logic [2:0] REG_SCRATCH   = 3'd2;
    localparam logic [2:0] REG_FRAME_CNT = 3'd3;
`ifdef VGA_AXIL_REGS_IRQ_EN
    localparam logic [2:0] REG_STATUS    = 3'd4;
    localparam logic [2:0] REG_IRQ_EN    = 3'd5;
`endif

    typedef enum logic {W_COLLECT, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP}    r_state_e;

    // Write path state.
    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [2:0]            waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    // Configuration registers.
    logic [1:0]            ctrl_q, ctrl_d;
    logic [11:0]           bg_q, bg_d;
    logic [31:0]           scratch_q, scratch_d;
    logic [31:0]           frame_cnt_q, frame_cnt_d;
`ifdef VGA_AXIL_REGS_IRQ_EN
    logic                  frame_pend_q, frame_pend_d;
    logic                  irq_en_q, irq_en_d;
    logic                  irq_q, irq_d;
`endif

    // Read path state.
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // Handshakes and the effective write beat (held copy or live bus).
    logic                  aw_hs, w_hs, ar_hs;
    logic                  aw_have, w_have;
    logic [2:0]            wa_eff;
    logic [DATA_W-1:0]     wd_eff;
    logic [DATA_W/8-1:0]   ws_eff;
    logic                  wr_ok;
    logic [DATA_W-1:0]     rd_val;
    logic                  rd_err;

    // Only addr[4:2] is decoded; the rest of both address buses is ignored.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{awaddr, araddr};

    assign aw_hs   = awvalid & awready_q;
    assign w_hs    = wvalid & wready_q;
    assign ar_hs   = arvalid & arready_q;
    assign aw_have = aw_held_q | aw_hs;
    assign w_have  = w_held_q | w_hs;
    assign wa_eff  = aw_held_q ? waddr_q : awaddr[4:2];
    assign wd_eff  = w_held_q ? wdata_q : wdata;
    assign ws_eff  = w_held_q ? wstrb_q : wstrb;

    // True for word indices that accept writes; FRAME_CNT and holes do not.
    function automatic logic wr_mapped(input logic [2:0] idx);
        case (idx)
            REG_CTRL, REG_BG_COLOR, REG_SCRATCH: return 1'b1;
`ifdef VGA_AXIL_REGS_IRQ_EN
            REG_STATUS, REG_IRQ_EN:              return 1'b1;
`endif
            default:                             return 1'b0;
        endcase
    endfunction

    // Write FSM: collect AW and W in any order, commit, then hold B until accepted.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no branch leaves one unassigned and infers a latch.
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        bg_d      = bg_q;
        scratch_d = scratch_q;
        wr_ok     = 1'b0;
`ifdef VGA_AXIL_REGS_IRQ_EN
        frame_pend_d = frame_pend_q;
        irq_en_d     = irq_en_q;
`endif
        unique case (w_state_q)
            W_COLLECT: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    waddr_d   = awaddr[4:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if (aw_have && w_have) begin
                    // Both halves present: commit on this edge and raise B next cycle.
                    wr_ok     = wr_mapped(wa_eff) && (ws_eff == '1);
                    bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                    if (wr_ok) begin
                        case (wa_eff)
                            REG_CTRL:     ctrl_d    = wd_eff[1:0];
                            REG_BG_COLOR: bg_d      = wd_eff[11:0];
                            REG_SCRATCH:  scratch_d = wd_eff;
`ifdef VGA_AXIL_REGS_IRQ_EN
                            REG_STATUS:   frame_pend_d = frame_pend_q & ~wd_eff[0];
                            REG_IRQ_EN:   irq_en_d     = wd_eff[0];
`endif
                            default:      ;
                        endcase
                    end
                end else begin
                    // Keep accepting whichever half is still missing.
                    awready_d = ~aw_have;
                    wready_d  = ~w_have;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_COLLECT;
                end
            end
            default: w_state_d = W_COLLECT;
        endcase
`ifdef VGA_AXIL_REGS_IRQ_EN
        // A frame_start in the same cycle as a W1C clear wins.
        frame_pend_d = frame_pend_d | frame_start;
        irq_d        = frame_pend_d & irq_en_d;
`endif
    end

    // Frame counter: free-running, wraps naturally at 2^32.
    always_comb begin
        frame_cnt_d = frame_cnt_q + {31'd0, frame_start};
    end

    // Read decode from current register values (a same-cycle write is not yet visible).
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        case (araddr[4:2])
            REG_CTRL:      rd_val = {30'd0, ctrl_q};
            REG_BG_COLOR:  rd_val = {20'd0, bg_q};
            REG_SCRATCH:   rd_val = scratch_q;
            REG_FRAME_CNT: rd_val = frame_cnt_q;
`ifdef VGA_AXIL_REGS_IRQ_EN
            REG_STATUS:    rd_val = {31'd0, frame_pend_q};
            REG_IRQ_EN:    rd_val = {31'd0, irq_en_q};
`endif
            default:       rd_err = 1'b1;
        endcase
    end

    // Read FSM: accept AR when idle, then hold R until accepted.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rdata_d   = rd_val;
                    rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write path and configuration registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            w_state_q <= W_COLLECT;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            ctrl_q    <= '0;
            bg_q      <= '0;
            scratch_q <= '0;
`ifdef VGA_AXIL_REGS_IRQ_EN
            frame_pend_q <= 1'b0;
            irq_en_q     <= 1'b0;
            irq_q        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ctrl_q    <= ctrl_d;
            bg_q      <= bg_d;
            scratch_q <= scratch_d;
`ifdef VGA_AXIL_REGS_IRQ_EN
            frame_pend_q <= frame_pend_d;
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
`endif
        end
    end

    // Read path registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign awready          = awready_q;
    assign wready           = wready_q;
    assign bvalid           = bvalid_q;
    assign bresp            = bresp_q;
    assign arready          = arready_q;
    assign rvalid           = rvalid_q;
    assign rdata            = rdata_q;
    assign rresp            = rresp_q;
    assign vga_en           = ctrl_q[0];
    assign vga_test_pattern = ctrl_q[1];
    assign vga_bg_rgb       = bg_q;
`ifdef VGA_AXIL_REGS_IRQ_EN
    assign irq              = irq_q;
`endif

endmodule

// File: tb/tb_vga_axil_regs.sv
// tb_vga_axil_regs: self-checking bench for vga_axil_regs.
// Expected B and R responses are queued when a transaction is driven and compared
// when the DUT presents them. Inputs are driven and outputs sampled on the falling edge.
module tb_vga_axil_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic        clk;
    logic        arst;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        frame_start;
    logic        vga_en;
    logic        vga_test_pattern;
    logic [11:0] vga_bg_rgb;
`ifdef VGA_AXIL_REGS_IRQ_EN
    logic        irq;
`endif

    logic [1:0]  b_q[$];
    r_exp_t      r_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    vga_axil_regs #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk              (clk),
        .arst             (arst),
        .awaddr           (awaddr),
        .awvalid          (awvalid),
        .awready          (awready),
        .wdata            (wdata),
        .wstrb            (wstrb),
        .wvalid           (wvalid),
        .wready           (wready),
        .bresp            (bresp),
        .bvalid           (bvalid),
        .bready           (bready),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .arready          (arready),
        .rdata            (rdata),
        .rresp            (rresp),
        .rvalid           (rvalid),
        .rready           (rready),
        .frame_start      (frame_start),
        .vga_en           (vga_en),
        .vga_test_pattern (vga_test_pattern),
        .vga_bg_rgb       (vga_bg_rgb)
`ifdef VGA_AXIL_REGS_IRQ_EN
        ,
        .irq              (irq)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Entered on a falling edge where bvalid must already be high; returns on a falling edge.
    task automatic finish_b(input string tag, input int hold);
        logic [1:0] e;
        e = 2'bxx;
        if (b_q.size() > 0) e = b_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold"}, 32'({bvalid, bresp}), 32'({1'b1, e}));
            @(negedge clk);
        end
        check({tag, "_bvalid"}, 32'(bvalid), 32'h1);
        check({tag, "_bresp"}, 32'(bresp), 32'(e));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check({tag, "_bdone"}, 32'({bvalid, awready, wready}), 32'h3);
    endtask

    // Entered on a falling edge where rvalid must already be high; returns on a falling edge.
    task automatic finish_r(input string tag);
        r_exp_t e;
        e = '{data: 32'hxxxx_xxxx, resp: 2'bxx};
        if (r_q.size() > 0) e = r_q.pop_front();
        check({tag, "_rvalid"}, 32'(rvalid), 32'h1);
        check({tag, "_rdata"}, rdata, e.data);
        check({tag, "_rresp"}, 32'(rresp), 32'(e.resp));
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check({tag, "_rdone"}, 32'({rvalid, arready}), 32'h1);
    endtask

    // W is presented w_lead cycles before AW; bready stays low for hold cycles once B is up.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input int hold, input logic [1:0] exp, input string tag);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        b_q.push_back(exp);
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            if (!aw_done && cyc >= w_lead) awvalid = 1'b1;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            if (aw_fire) begin
                aw_done = 1'b1;
                awvalid = 1'b0;
            end
            if (w_fire) begin
                w_done = 1'b1;
                wvalid = 1'b0;
                if (!aw_done) check({tag, "_wready_drop"}, 32'(wready), 32'h0);
            end
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check({tag, "_handshakes"}, 32'({aw_done, w_done}), 32'h3);
        finish_b(tag, hold);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input string tag);
        bit fired, f;
        int cyc;
        fired = 1'b0;
        cyc   = 0;
        r_q.push_back('{data: exp_d, resp: exp_r});
        araddr  = addr;
        arvalid = 1'b1;
        while (!fired && cyc < 20) begin
            f = arready;
            @(negedge clk);
            if (f) begin
                fired   = 1'b1;
                arvalid = 1'b0;
            end
            cyc++;
        end
        arvalid = 1'b0;
        check({tag, "_ar_hs"}, 32'(fired), 32'h1);
        finish_r(tag);
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        arst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0; frame_start = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_hs", 32'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_vga", 32'({vga_en, vga_test_pattern, vga_bg_rgb}), 32'h0);
        arst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'({awready, wready, arready}), 32'h7);

        // Concurrent AW/W to SCRATCH, then read back.
        do_write(8'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, OKAY, "wr_scratch");
        do_read(8'h08, 32'hDEAD_BEEF, OKAY, "rd_scratch");

        // W three cycles ahead of AW, bready held low five cycles.
        do_write(8'h04, 32'h0000_0ABC, 4'hF, 3, 5, OKAY, "wr_bg");
        check("vga_bg", 32'(vga_bg_rgb), 32'h0ABC);
        do_read(8'h04, 32'h0000_0ABC, OKAY, "rd_bg");

        // Same-cycle write and read of SCRATCH: the read sees the pre-write value.
        b_q.push_back(OKAY);
        r_q.push_back('{data: 32'hDEAD_BEEF, resp: OKAY});
        awaddr = 8'h08; wdata = 32'hCAFE_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h08; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        finish_b("wr_same", 0);
        finish_r("rd_same");
        do_read(8'h08, 32'hCAFE_0000, OKAY, "rd_after_same");

        // Error responses.
        do_write(8'h0C, 32'h0000_0005, 4'hF, 0, 0, SLVERR, "wr_framecnt");
        do_read(8'h0C, 32'h0, OKAY, "rd_framecnt0");
        do_write(8'h00, 32'h0000_0003, 4'h3, 0, 0, SLVERR, "wr_ctrl_strb");
        check("vga_en_strb", 32'(vga_en), 32'h0);
        do_read(8'h1C, 32'h0, SLVERR, "rd_unmapped");
        do_write(8'h18, 32'h1234_5678, 4'hF, 1, 0, SLVERR, "wr_unmapped");
`ifndef VGA_AXIL_REGS_IRQ_EN
        do_read(8'h10, 32'h0, SLVERR, "rd_status_absent");
        do_write(8'h14, 32'h1, 4'hF, 0, 0, SLVERR, "wr_irqen_absent");
`endif

        // CTRL: only bits [1:0] stick.
        do_write(8'h00, 32'hFFFF_FFFE, 4'hF, 0, 0, OKAY, "wr_ctrl_hi");
        check("ctrl_hi_vga", 32'({vga_en, vga_test_pattern}), 32'h1);
        do_read(8'h00, 32'h0000_0002, OKAY, "rd_ctrl_hi");
        do_write(8'h00, 32'h0000_0003, 4'hF, 0, 0, OKAY, "wr_ctrl");
        check("ctrl_vga", 32'({vga_en, vga_test_pattern}), 32'h3);

        // Frame counter and wrap.
        pulse_frames(10);
        do_read(8'h0C, 32'd10, OKAY, "rd_frames10");
        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt_q;
        @(negedge clk);
        do_read(8'h0C, 32'hFFFF_FFFF, OKAY, "rd_frames_max");
        pulse_frames(1);
        do_read(8'h0C, 32'h0, OKAY, "rd_frames_wrap");

        // Asynchronous reset with B and R both pending.
        awaddr = 8'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h08; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("pre_rst_valids", 32'({bvalid, rvalid}), 32'h3);
        #2 arst = 1'b1;
        #1 check("async_rst_hs", 32'({awready, wready, arready, bvalid, rvalid}), 32'h0);
        check("async_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        check("rerst_ready", 32'({awready, wready, arready}), 32'h7);
        do_read(8'h00, 32'h0, OKAY, "rd_ctrl_rst");
        check("rst_vga_en", 32'(vga_en), 32'h0);
        do_write(8'h08, 32'h1234_5678, 4'hF, 2, 1, OKAY, "wr_after_rst");
        do_read(8'h08, 32'h1234_5678, OKAY, "rd_after_rst");

`ifdef VGA_AXIL_REGS_IRQ_EN
        // Interrupt: enable, pulse, same-cycle set/clear, then a plain clear.
        do_write(8'h10, 32'h1, 4'hF, 0, 0, OKAY, "wr_status_clr0");
        do_write(8'h14, 32'h1, 4'hF, 0, 0, OKAY, "wr_irq_en");
        check("irq_idle", 32'(irq), 32'h0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("irq_set", 32'(irq), 32'h1);
        do_read(8'h10, 32'h1, OKAY, "rd_status_set");
        b_q.push_back(OKAY);
        awaddr = 8'h10; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; frame_start = 1'b0;
        check("irq_set_wins", 32'(irq), 32'h1);
        finish_b("wr_status_race", 0);
        do_read(8'h10, 32'h1, OKAY, "rd_status_race");
        do_write(8'h10, 32'h1, 4'hF, 0, 0, OKAY, "wr_status_clr");
        check("irq_clear", 32'(irq), 32'h0);
        do_read(8'h14, 32'h1, OKAY, "rd_irq_en");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_axil_regs.md
Name: vga_axil_regs

Overview:
AXI-Lite slave register file that terminates the VGA AXI-Lite bus and drives the static configuration of the VGA timing/pixel pipeline. It decodes 32-bit word registers, performs the AW/W/B and AR/R handshakes, and exports control fields to the pixel stage. It also exports a frame counter fed by a frame-start pulse from the timing generator. It sits directly downstream of the AXI-Lite master and directly upstream of the VGA core.

Parameters:
ADDR_W, 8, AXI-Lite address width in bits; only addr[4:2] are decoded, addr[1:0] are ignored.
DATA_W, 32, AXI-Lite data width; fixed at 32, any other value is a $fatal at elaboration.

Ports:
clk  in  1  system clock, all logic on rising edge
arst  in  1  asynchronous active-high reset
awaddr  in  ADDR_W  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  write strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_W  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
frame_start  in  1  one-cycle pulse at start of each VGA frame
vga_en  out  1  CTRL[0], enables VGA output
vga_test_pattern  out  1  CTRL[1], selects test pattern
vga_bg_rgb  out  12  BG_COLOR[11:0], RGB444 background

Behaviour:
- Reset (arst=1, asynchronous): all ready/valid outputs 0, bresp=rresp=0, rdata=0, all registers 0, holding flags cleared; any in-flight transaction is dropped without a response.
- First rising edge after reset release: awready=wready=arready=1.
- Register map (byte offset):
  - 0x00 CTRL: RW, bits[1:0]; other bits read 0.
  - 0x04 BG_COLOR: RW, bits[11:0].
  - 0x08 SCRATCH: RW, 32 bits.
  - 0x0C FRAME_CNT: RO.
  - Other offsets: unmapped.
- Responses: OKAY=2'b00, SLVERR=2'b10.
- Write path, states W_COLLECT and W_RESP:
  - W_COLLECT: AW and W are accepted independently. An AW handshake latches awaddr, sets aw_held and drops awready. A W handshake latches wdata/wstrb, sets w_held and drops wready. Same-cycle handshake on both is allowed.
  - When aw_held and w_held are both set: the register update happens on that edge, then go to W_RESP with bvalid=1. Write-to-bvalid latency is 1 cycle after the later of the two handshakes.
  - bresp=SLVERR and no update when wstrb!=4'hF, the target is unmapped, or the target is FRAME_CNT. Otherwise OKAY.
  - W_RESP: bvalid and bresp are held stable until bready. On the handshake: bvalid=0, flags cleared, awready=wready=1 on the next cycle, return to W_COLLECT.
- Read path, states R_IDLE and R_RESP:
  - R_IDLE: arready=1. An AR handshake captures the decoded data into rdata, sets rvalid=1 on the next edge and drops arready (latency 1).
  - Unmapped address: rdata=0, rresp=SLVERR. Mapped: OKAY.
  - R_RESP: rdata/rresp/rvalid are held stable until rready. On the handshake: rvalid=0, arready=1 next cycle.
- Read and write paths are independent.
  - A read of a register updated in the same cycle returns the pre-write value.
- FRAME_CNT: increments by 1 on each clk edge with frame_start=1. Wraps 32'hFFFF_FFFF to 0. Counts regardless of CTRL.
- vga_* outputs are direct register outputs: they change on the edge that completes the write.
- No X on any output after reset. All outputs are registered.

Optional Feature:
Macro: VGA_AXIL_REGS_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0).
  - Adds register 0x10 STATUS, bit0 frame_pend, W1C: set by frame_start, cleared by writing 1. If set and clear occur in the same cycle, set wins.
  - Adds register 0x14 IRQ_EN, RW, bit0.
  - irq is registered: irq = frame_pend & IRQ_EN[0].
- Not defined: irq port absent; 0x10 and 0x14 are unmapped (SLVERR).

Test Plan:
- Reset, then write 0x08 <= 32'hDEAD_BEEF with AW/W concurrent, then read 0x08 -> bresp=OKAY, rdata=32'hDEAD_BEEF, rresp=OKAY; rvalid rises exactly 1 cycle after the AR handshake.
- W presented 3 cycles before AW: write 0x04 <= 32'h0000_0ABC -> wready drops after the W handshake, bvalid 1 cycle after the AW handshake, vga_bg_rgb=12'hABC. With bready held low 5 cycles, bvalid/bresp are stable throughout.
- Write 0x0C <= 5 -> SLVERR, FRAME_CNT unchanged. Write 0x00 <= 3 with wstrb=4'h3 -> SLVERR, vga_en=0. Read 0x1C -> SLVERR, rdata=0.
- Pulse frame_start 10 times, then read 0x0C -> 10. Force the counter to 32'hFFFF_FFFF, one pulse -> 0.
- Assert arst while bvalid=1 and rvalid=1 -> all valids and readies 0 immediately. After release, a read of 0x00 returns 0 and a new transaction completes normally.
- With VGA_AXIL_REGS_IRQ_EN: IRQ_EN <= 1, pulse frame_start -> irq=1 next cycle. Write STATUS <= 1 in the same cycle as a frame_start pulse -> frame_pend stays 1. A later clear with no pulse -> irq=0.
